// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and default sizing for the MEM stage
package mem_stage_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts stalled WAIT cycles and flags the abort point
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  logic [7:0] cnt_q;
  // zero while idle so every access starts counting from 0
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 8'd1;
  end
  assign hit_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage sequencing data-memory accesses into MEM/WB
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VALID_IN,
  input  logic             MEMWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             REGWRITE_IN,
  input  logic [WIDTH-1:0] RESULTOP_IN,
  input  logic [WIDTH-1:0] WRDATA_IN,
  input  logic [4:0]       ARD_IN,
  output logic             STALL_OUT,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0] MEM_WDATA,
  input  logic             MEM_READY,
  input  logic [WIDTH-1:0] MEM_RDATA,
  output logic             VALID_OUT,
  output logic             REGWRITE_OUT,
  output logic [WIDTH-1:0] WBDATA_OUT,
  output logic [4:0]       ARD_OUT,
  output logic             ERR_OUT
);
  state_t state_q, state_d;
  logic valid_q, valid_d, err_q, err_d, rw_q, rw_d;
  logic [WIDTH-1:0] wb_q, wb_d, h_addr_q, h_addr_d, h_wdata_q, h_wdata_d;
  logic [4:0] ard_q, ard_d, h_ard_q, h_ard_d;
  logic h_we_q, h_we_d, h_rw_q, h_rw_d;
  logic hit, in_wait, mem_op;
  assign in_wait = state_q == WAIT;
  assign mem_op = MEMWRITE_IN || MEMTOREG_IN;
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr_i(!in_wait),
    .en_i(in_wait && !MEM_READY),
    .hit_o(hit)
  );
  assign STALL_OUT = in_wait && !MEM_READY && !hit;
  assign MEM_REQ = in_wait;
  assign MEM_WE = h_we_q;
  assign MEM_ADDR = h_addr_q;
  assign MEM_WDATA = h_wdata_q;
  assign VALID_OUT = valid_q;
  assign ERR_OUT = err_q;
  assign REGWRITE_OUT = rw_q;
  assign WBDATA_OUT = wb_q;
  assign ARD_OUT = ard_q;
  // next state: pass-through, misalign abort or capture in IDLE; completion or timeout in WAIT
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    rw_d = 1'b0;
    wb_d = wb_q;
    ard_d = ard_q;
    h_addr_d = h_addr_q;
    h_wdata_d = h_wdata_q;
    h_ard_d = h_ard_q;
    h_we_d = h_we_q;
    h_rw_d = h_rw_q;
    if (!in_wait) begin
      if (VALID_IN && !mem_op) begin
        valid_d = 1'b1;
        wb_d = RESULTOP_IN;
        rw_d = REGWRITE_IN;
        ard_d = ARD_IN;
      end else if (VALID_IN && RESULTOP_IN[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else if (VALID_IN) begin
        state_d = WAIT;
        h_addr_d = RESULTOP_IN;
        h_wdata_d = WRDATA_IN;
        h_ard_d = ARD_IN;
        h_we_d = MEMWRITE_IN;
        h_rw_d = REGWRITE_IN;
      end
    end else if (MEM_READY) begin
      state_d = IDLE;
      valid_d = 1'b1;
      ard_d = h_ard_q;
      wb_d = h_we_q ? h_addr_q : MEM_RDATA;
      rw_d = !h_we_q && h_rw_q;
    end else if (hit) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
  end
  // state, holding and MEM/WB registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      rw_q <= 1'b0;
      wb_q <= '0;
      ard_q <= '0;
      h_addr_q <= '0;
      h_wdata_q <= '0;
      h_ard_q <= '0;
      h_we_q <= 1'b0;
      h_rw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q <= err_d;
      rw_q <= rw_d;
      wb_q <= wb_d;
      ard_q <= ard_d;
      h_addr_q <= h_addr_d;
      h_wdata_q <= h_wdata_d;
      h_ard_q <= h_ard_d;
      h_we_q <= h_we_d;
      h_rw_q <= h_rw_d;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and randomized checks of mem_stage_ctrl against a transaction model
module tb_mem_stage_ctrl;
  localparam int T = 16;
  logic clk = 0, rst = 1;
  logic VALID_IN = 0, MEMWRITE_IN = 0, MEMTOREG_IN = 0, REGWRITE_IN = 0, MEM_READY = 0;
  logic [31:0] RESULTOP_IN = 0, WRDATA_IN = 0, MEM_RDATA = 0;
  logic [4:0] ARD_IN = 0;
  logic STALL_OUT, MEM_REQ, MEM_WE, VALID_OUT, REGWRITE_OUT, ERR_OUT;
  logic [31:0] MEM_ADDR, MEM_WDATA, WBDATA_OUT;
  logic [4:0] ARD_OUT;
  int total = 0, bad = 0;

  mem_stage_ctrl #(.WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .VALID_IN(VALID_IN), .MEMWRITE_IN(MEMWRITE_IN),
    .MEMTOREG_IN(MEMTOREG_IN), .REGWRITE_IN(REGWRITE_IN), .RESULTOP_IN(RESULTOP_IN),
    .WRDATA_IN(WRDATA_IN), .ARD_IN(ARD_IN), .STALL_OUT(STALL_OUT), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY),
    .MEM_RDATA(MEM_RDATA), .VALID_OUT(VALID_OUT), .REGWRITE_OUT(REGWRITE_OUT),
    .WBDATA_OUT(WBDATA_OUT), .ARD_OUT(ARD_OUT), .ERR_OUT(ERR_OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transaction-level model: one outstanding access with a count of cycles already waited
  bit m_busy = 0, m_store = 0, m_rw = 0;
  int m_n = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [4:0] m_ard = 0;
  bit e_valid = 0, e_err = 0, e_rw = 0;
  logic [31:0] e_wb = 0;
  logic [4:0] e_ard = 0;

  always @(posedge clk) begin
    e_valid = 0;
    e_err = 0;
    e_rw = 0;
    if (rst) begin
      m_busy = 0;
      m_store = 0;
      m_rw = 0;
      m_addr = 0;
      m_wdata = 0;
      m_ard = 0;
      e_wb = 0;
      e_ard = 0;
    end else if (m_busy) begin
      if (MEM_READY) begin
        e_valid = 1;
        e_ard = m_ard;
        e_wb = m_store ? m_addr : MEM_RDATA;
        e_rw = m_store ? 1'b0 : m_rw;
        m_busy = 0;
      end else if (m_n == T - 1) begin
        e_err = 1;
        m_busy = 0;
      end else m_n++;
    end else if (VALID_IN) begin
      if (!MEMWRITE_IN && !MEMTOREG_IN) begin
        e_valid = 1;
        e_wb = RESULTOP_IN;
        e_rw = REGWRITE_IN;
        e_ard = ARD_IN;
      end else if (RESULTOP_IN % 4 != 0) e_err = 1;
      else begin
        m_busy = 1;
        m_n = 0;
        m_store = MEMWRITE_IN;
        m_rw = REGWRITE_IN;
        m_addr = RESULTOP_IN;
        m_wdata = WRDATA_IN;
        m_ard = ARD_IN;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_req", MEM_REQ, m_busy);
    chk("m_stall", STALL_OUT, m_busy && !MEM_READY && m_n != T - 1);
    if (m_busy) begin
      chk("m_we", MEM_WE, m_store);
      chk("m_addr", MEM_ADDR, m_addr);
      chk("m_wdata", MEM_WDATA, m_wdata);
    end
    chk("m_valid", VALID_OUT, e_valid);
    chk("m_err", ERR_OUT, e_err);
    chk("m_rw", REGWRITE_OUT, e_rw);
    chk("m_wb", WBDATA_OUT, e_wb);
    chk("m_ard", ARD_OUT, e_ard);
  end

  task automatic load(input logic [31:0] a, input logic [4:0] rd);
    VALID_IN = 1;
    MEMWRITE_IN = 0;
    MEMTOREG_IN = 1;
    REGWRITE_IN = 1;
    RESULTOP_IN = a;
    ARD_IN = rd;
    MEM_READY = 0;
    tick();
    VALID_IN = 0;
  endtask

  initial begin
    int n;
    int pr;
    repeat (2) tick();
    chk("rst_valid", VALID_OUT, 0);
    chk("rst_err", ERR_OUT, 0);
    chk("rst_wb", WBDATA_OUT, 0);
    chk("rst_ard", ARD_OUT, 0);
    chk("rst_req", MEM_REQ, 0);
    rst = 0;
    tick();
    VALID_IN = 1;
    REGWRITE_IN = 1;
    RESULTOP_IN = 32'hAA;
    ARD_IN = 5;
    tick();
    VALID_IN = 0;
    chk("alu_valid", VALID_OUT, 1);
    chk("alu_wb", WBDATA_OUT, 32'hAA);
    chk("alu_ard", ARD_OUT, 5);
    chk("alu_stall", STALL_OUT, 0);
    load(32'h40, 7);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", STALL_OUT, 1);
      tick();
    end
    MEM_READY = 1;
    MEM_RDATA = 32'hDEADBEEF;
    #1;
    chk("ld_stall_end", STALL_OUT, 0);
    tick();
    MEM_READY = 0;
    chk("ld_valid", VALID_OUT, 1);
    chk("ld_wb", WBDATA_OUT, 32'hDEADBEEF);
    chk("ld_rw", REGWRITE_OUT, 1);
    chk("ld_ard", ARD_OUT, 7);
    VALID_IN = 1;
    MEMWRITE_IN = 1;
    MEMTOREG_IN = 0;
    REGWRITE_IN = 1;
    RESULTOP_IN = 32'h100;
    WRDATA_IN = 32'h1234;
    ARD_IN = 3;
    tick();
    VALID_IN = 0;
    MEM_READY = 1;
    #1;
    chk("st_req", MEM_REQ, 1);
    chk("st_we", MEM_WE, 1);
    chk("st_addr", MEM_ADDR, 32'h100);
    chk("st_wdata", MEM_WDATA, 32'h1234);
    tick();
    MEM_READY = 0;
    chk("st_valid", VALID_OUT, 1);
    chk("st_rw", REGWRITE_OUT, 0);
    chk("st_wb", WBDATA_OUT, 32'h100);
    VALID_IN = 1;
    MEMWRITE_IN = 0;
    MEMTOREG_IN = 1;
    RESULTOP_IN = 32'h102;
    tick();
    VALID_IN = 0;
    chk("mis_err", ERR_OUT, 1);
    chk("mis_valid", VALID_OUT, 0);
    chk("mis_req", MEM_REQ, 0);
    tick();
    chk("mis_err_end", ERR_OUT, 0);
    load(32'h200, 9);
    n = 0;
    while (MEM_REQ === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 16);
    chk("to_err", ERR_OUT, 1);
    chk("to_valid", VALID_OUT, 0);
    chk("to_stall", STALL_OUT, 0);
    load(32'h204, 10);
    repeat (15) tick();
    MEM_READY = 1;
    MEM_RDATA = 32'h55AA55AA;
    #1;
    chk("late_req", MEM_REQ, 1);
    tick();
    MEM_READY = 0;
    chk("late_valid", VALID_OUT, 1);
    chk("late_err", ERR_OUT, 0);
    chk("late_wb", WBDATA_OUT, 32'h55AA55AA);
    load(32'h300, 11);
    tick();
    rst = 1;
    tick();
    rst = 0;
    MEM_READY = 1;
    #1;
    chk("rw_req", MEM_REQ, 0);
    chk("rw_valid", VALID_OUT, 0);
    tick();
    chk("rw_req2", MEM_REQ, 0);
    chk("rw_valid2", VALID_OUT, 0);
    MEM_READY = 0;
    for (int c = 0; c < 4000; c++) begin
      pr = ((c / 500) % 2 == 1) ? 25 : 3;
      rst = $urandom_range(149) == 0;
      VALID_IN = $urandom_range(3) != 0;
      MEMWRITE_IN = 1'($urandom_range(1));
      MEMTOREG_IN = 1'($urandom_range(1));
      REGWRITE_IN = 1'($urandom_range(1));
      RESULTOP_IN = $urandom;
      if ($urandom_range(3) != 0) RESULTOP_IN[1:0] = 2'b00;
      WRDATA_IN = $urandom;
      ARD_IN = 5'($urandom_range(31));
      MEM_READY = $urandom_range(pr - 1) == 0;
      MEM_RDATA = $urandom;
      tick();
    end
    rst = 0;
    VALID_IN = 0;
    MEM_READY = 0;
    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
